load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/load_align.sv | 26 ++
 rtl/load_store_unit.sv | 133 +++++++++++++
 tb/tb_load_store_unit.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Types shared by the load/store unit and the control unit: memory-access
// width encodings, the LSU state type and an alignment helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE    = 2'b00,
    MEM_HALF    = 2'b01,
    MEM_WORD    = 2'b10,
    MEM_ILLEGAL = 2'b11
  } mem_width_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBus  = 2'b01,
    StResp = 2'b10
  } lsu_state_e;

  // Illegal widths count as misaligned so they never reach the bus.
  function automatic logic is_misaligned(input mem_width_e width, input logic [1:0] offset);
    logic mis;
    case (width)
      MEM_BYTE: mis = 1'b0;
      MEM_HALF: mis = offset[0];
      MEM_WORD: mis = |offset;
      default:  mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction: moves the addressed lane down to bit 0, masks it to
// the access width and sign- or zero-extends it.
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] bus_rdata,
  input  logic [1:0]  offset,
  input  mem_width_e  width,
  input  logic        zero_extend,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = bus_rdata >> {offset, 3'b000};
    load_data = '0;
    case (width)
      MEM_BYTE: load_data = {{24{~zero_extend & shifted[7]}}, shifted[7:0]};
      MEM_HALF: load_data = {{16{~zero_extend & shifted[15]}}, shifted[15:0]};
      MEM_WORD: load_data = shifted;
      default:  load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one decoded memory op, runs at most one bus
// transfer for it and reports completion with a single-cycle response pulse.
module load_store_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_width,
  input  logic        mem_zero_extend,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  lsu_state_e  state_q;
  logic [1:0]  offset_q;
  mem_width_e  width_q;
  logic        zext_q;

  mem_width_e  req_width;
  logic        req_misaligned;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic [31:0] load_data;

  assign req_width      = mem_width_e'(mem_width);
  assign req_misaligned = is_misaligned(req_width, addr[1:0]);
  assign req_ready      = (state_q == StIdle);

  // Store lanes: strobe and replicated data for the addressed bytes.
  always_comb begin
    req_wstrb = 4'b0000;
    req_wdata = wdata;
    case (req_width)
      MEM_BYTE: begin
        req_wstrb = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      MEM_HALF: begin
        req_wstrb = 4'b0011 << addr[1:0];
        req_wdata = {2{wdata[15:0]}};
      end
      MEM_WORD: begin
        req_wstrb = 4'b1111;
        req_wdata = wdata;
      end
      default: begin
        req_wstrb = 4'b0000;
        req_wdata = wdata;
      end
    endcase
  end

  load_align u_load_align (
    .bus_rdata   (bus_rdata),
    .offset      (offset_q),
    .width       (width_q),
    .zero_extend (zext_q),
    .load_data   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      offset_q   <= 2'b00;
      width_q    <= MEM_BYTE;
      zext_q     <= 1'b0;
      resp_valid <= 1'b0;
      rdata      <= '0;
      misaligned <= 1'b0;
      bus_valid  <= 1'b0;
      bus_addr   <= '0;
      bus_we     <= 1'b0;
      bus_wstrb  <= 4'b0000;
      bus_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            offset_q <= addr[1:0];
            width_q  <= req_width;
            zext_q   <= mem_zero_extend;
            if (!(mem_read || mem_write)) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              rdata      <= '0;
              misaligned <= 1'b0;
            end else if (req_misaligned) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              rdata      <= '0;
              misaligned <= 1'b1;
            end else begin
              // Write wins when decode asserts both kinds.
              state_q   <= StBus;
              bus_valid <= 1'b1;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_we    <= mem_write;
              bus_wstrb <= mem_write ? req_wstrb : 4'b0000;
              bus_wdata <= mem_write ? req_wdata : '0;
            end
          end
        end
        StBus: begin
          if (bus_ready) begin
            state_q    <= StResp;
            bus_valid  <= 1'b0;
            resp_valid <= 1'b1;
            misaligned <= 1'b0;
            rdata      <= bus_we ? '0 : load_data;
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// ops compared against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_width = 2'b00;
  logic        mem_zero_extend = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        misaligned;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  load_store_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_width       (mem_width),
    .mem_zero_extend (mem_zero_extend),
    .addr            (addr),
    .wdata           (wdata),
    .resp_valid      (resp_valid),
    .rdata           (rdata),
    .misaligned      (misaligned),
    .bus_valid       (bus_valid),
    .bus_ready       (bus_ready),
    .bus_addr        (bus_addr),
    .bus_we          (bus_we),
    .bus_wstrb       (bus_wstrb),
    .bus_wdata       (bus_wdata),
    .bus_rdata       (bus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          bus;
    logic [31:0] baddr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    int          lat;
  } exp_t;

  typedef struct {
    bit          ready_start;
    int          accept_cyc;
    int          lat;
    bit          timeout;
    bit          saw_bus;
    logic [31:0] baddr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    bit          stable;
    bit          ready_low;
    logic [31:0] rdata;
    logic        mis;
    bit          pulse_ok;
    bit          held_ok;
    bit          ready_after;
  } obs_t;

  // Reference model: expected behaviour from size/offset arithmetic.
  function automatic exp_t model(input bit rd, input bit wr, input logic [1:0] w, input bit ze,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] br, input int waits);
    exp_t   e;
    int     size;
    int     off;
    longint span;
    longint v;
    e.bus = 0; e.baddr = '0; e.we = 0; e.wstrb = '0; e.wdata = '0;
    e.rdata = '0; e.mis = 0; e.lat = 1;
    if (!(rd || wr)) return e;
    size = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : (w == 2'd2) ? 4 : 0;
    off  = int'(a % 4);
    if (size == 0 || (a % size) != 0) begin
      e.mis = 1;
      return e;
    end
    e.bus   = 1;
    e.lat   = 2 + waits;
    e.baddr = a - off;
    if (wr) begin
      e.we    = 1;
      e.wstrb = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
    end else begin
      span = longint'(1) << (8 * size);
      v    = (longint'(br) >> (8 * off)) % span;
      if (!ze && v >= span / 2) v = v - span;
      e.rdata = 32'(v);
    end
    return e;
  endfunction

  // Drives one op from a negedge, plays the bus slave with the given number of
  // wait states, and returns what was observed. Ends on the negedge after RESP.
  task automatic run_op(input bit rd, input bit wr, input logic [1:0] w, input bit ze,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] br,
                        input int waits, output obs_t o);
    int nbus;
    o.saw_bus = 0; o.baddr = '0; o.we = 0; o.wstrb = '0; o.wdata = '0;
    o.stable = 1; o.ready_low = 1; o.timeout = 1;
    o.ready_start = req_ready;
    req_valid = 1'b1; mem_read = rd; mem_write = wr; mem_width = w;
    mem_zero_extend = ze; addr = a; wdata = wd; bus_rdata = br; bus_ready = 1'b0;
    @(posedge clk);
    o.accept_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    o.lat = 1;
    nbus  = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid === 1'b1) begin
        o.timeout = 0;
        break;
      end
      if (req_ready !== 1'b0) o.ready_low = 0;
      if (bus_valid === 1'b1) begin
        if (!o.saw_bus) begin
          o.baddr = bus_addr; o.we = bus_we; o.wstrb = bus_wstrb; o.wdata = bus_wdata;
        end else if (bus_addr !== o.baddr || bus_we !== o.we || bus_wstrb !== o.wstrb ||
                     bus_wdata !== o.wdata) begin
          o.stable = 0;
        end
        o.saw_bus = 1;
        bus_ready = (nbus >= waits);
        nbus++;
      end
      @(negedge clk);
      o.lat++;
    end
    o.rdata = rdata;
    o.mis   = misaligned;
    if (req_ready !== 1'b0) o.ready_low = 0;
    bus_ready = 1'b0;
    @(negedge clk);
    o.pulse_ok    = (resp_valid === 1'b0);
    o.held_ok     = (rdata === o.rdata) && (misaligned === o.mis);
    o.ready_after = (req_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus_valid, resp_valid, misaligned} !== 3'b000) begin
      bad++;
      $display("FAIL reset_async_flags: got %b want 000", {bus_valid, resp_valid, misaligned});
    end
    total++;
    if ({rdata, bus_addr, bus_we, bus_wstrb, bus_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_async_data: rdata=%h bus_addr=%h we=%b wstrb=%b wdata=%h want all 0",
               rdata, bus_addr, bus_we, bus_wstrb, bus_wdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
    total++;
    if ({bus_valid, resp_valid, rdata, misaligned} !== '0) begin
      bad++;
      $display("FAIL reset_released_idle: bus_valid=%b resp_valid=%b rdata=%h mis=%b want 0",
               bus_valid, resp_valid, rdata, misaligned);
    end
  endtask

  task automatic test_byte_store();
    obs_t o;
    run_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, o);
    total++;
    if ({o.saw_bus, o.baddr, o.we} !== {1'b1, 32'h0000_1000, 1'b1}) begin
      bad++;
      $display("FAIL byte_store_addr: got bus=%b addr=%h we=%b want 1 00001000 1",
               o.saw_bus, o.baddr, o.we);
    end
    total++;
    if (o.wstrb !== 4'b1000 || o.wdata !== 32'hABAB_ABAB) begin
      bad++;
      $display("FAIL byte_store_lanes: got wstrb=%b wdata=%h want 1000 abababab", o.wstrb, o.wdata);
    end
    total++;
    if (o.lat !== 2 || o.timeout) begin
      bad++;
      $display("FAIL byte_store_latency: got %0d want 2", o.lat);
    end
    total++;
    if (o.rdata !== 32'h0 || o.mis !== 1'b0 || !o.pulse_ok) begin
      bad++;
      $display("FAIL byte_store_resp: got rdata=%h mis=%b pulse_ok=%b want 0 0 1",
               o.rdata, o.mis, o.pulse_ok);
    end
  endtask

  task automatic test_half_load();
    obs_t o;
    run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, o);
    total++;
    if (o.rdata !== 32'hFFFF_8001) begin
      bad++;
      $display("FAIL half_load_signed: got %h want ffff8001", o.rdata);
    end
    total++;
    if (o.wstrb !== 4'b0000 || o.we !== 1'b0 || o.baddr !== 32'h0000_2000) begin
      bad++;
      $display("FAIL half_load_bus: got wstrb=%b we=%b addr=%h want 0000 0 00002000",
               o.wstrb, o.we, o.baddr);
    end
    run_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, o);
    total++;
    if (o.rdata !== 32'h0000_8001 || o.lat !== 2) begin
      bad++;
      $display("FAIL half_load_zero: got rdata=%h lat=%0d want 00008001 2", o.rdata, o.lat);
    end
  endtask

  task automatic test_byte_load_sign();
    obs_t o;
    run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_4001, 32'h0, 32'h0000_9C00, 0, o);
    total++;
    if (o.rdata !== 32'hFFFF_FF9C) begin
      bad++;
      $display("FAIL byte_load_signed: got %h want ffffff9c", o.rdata);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'hDEAD_BEEF, 0, o);
    total++;
    if (o.saw_bus || o.lat !== 1 || o.mis !== 1'b1 || o.rdata !== 32'h0) begin
      bad++;
      $display("FAIL misaligned_word: got bus=%b lat=%0d mis=%b rdata=%h want 0 1 1 0",
               o.saw_bus, o.lat, o.mis, o.rdata);
    end
    run_op(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_3000, 32'h1234_5678, 32'h0, 0, o);
    total++;
    if (o.saw_bus || o.lat !== 1 || o.mis !== 1'b1) begin
      bad++;
      $display("FAIL illegal_width: got bus=%b lat=%0d mis=%b want 0 1 1", o.saw_bus, o.lat, o.mis);
    end
    run_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_3003, 32'h0, 32'hFFFF_FFFF, 0, o);
    total++;
    if (o.saw_bus || o.lat !== 1 || o.mis !== 1'b0 || o.rdata !== 32'h0 || !o.pulse_ok) begin
      bad++;
      $display("FAIL noop: got bus=%b lat=%0d mis=%b rdata=%h pulse=%b want 0 1 0 0 1",
               o.saw_bus, o.lat, o.mis, o.rdata, o.pulse_ok);
    end
  endtask

  task automatic test_wait_states();
    obs_t o;
    run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_5004, 32'hCAFE_F00D, 32'h0, 3, o);
    total++;
    if (!o.stable || o.wdata !== 32'hCAFE_F00D || o.wstrb !== 4'b1111) begin
      bad++;
      $display("FAIL wait_stable: got stable=%b wdata=%h wstrb=%b want 1 cafef00d 1111",
               o.stable, o.wdata, o.wstrb);
    end
    total++;
    if (o.lat !== 5 || o.timeout) begin
      bad++;
      $display("FAIL wait_latency: got %0d want 5", o.lat);
    end
    total++;
    if (!o.ready_low || !o.ready_after) begin
      bad++;
      $display("FAIL wait_req_ready: got low_during=%b high_after=%b want 1 1",
               o.ready_low, o.ready_after);
    end
  endtask

  task automatic test_reset_mid_bus();
    obs_t o;
    bit   spurious;
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_width = 2'b10;
    addr = 32'h0000_6000; bus_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; mem_read = 1'b0;
    total++;
    if (bus_valid !== 1'b1) begin
      bad++;
      $display("FAIL midbus_started: got bus_valid=%b want 1", bus_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus_valid !== 1'b0 || bus_addr !== 32'h0 || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL midbus_drop: got bus_valid=%b bus_addr=%h resp=%b want 0 0 0",
               bus_valid, bus_addr, resp_valid);
    end
    bus_ready = 1'b1;
    spurious = 0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) spurious = 1;
    end
    rst_n = 1'b1;
    bus_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || bus_valid !== 1'b0) spurious = 1;
    end
    total++;
    if (spurious) begin
      bad++;
      $display("FAIL midbus_no_resp: got a response or bus cycle after abandon, want none");
    end
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_6004, 32'h0, 32'h1357_9BDF, 1, o);
    total++;
    if (!o.ready_start || o.rdata !== 32'h1357_9BDF || o.lat !== 3) begin
      bad++;
      $display("FAIL midbus_recover: got ready=%b rdata=%h lat=%0d want 1 13579bdf 3",
               o.ready_start, o.rdata, o.lat);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2, o3, o4;
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'h0, 32'h1111_1111, 0, o1);
    run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_7002, 32'h0000_BEEF, 32'h0, 0, o2);
    run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_7001, 32'h0, 32'h0, 0, o3);
    run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_7003, 32'h0, 32'hF000_0000, 0, o4);
    total++;
    if (o2.accept_cyc - o1.accept_cyc !== 3 || o3.accept_cyc - o2.accept_cyc !== 3) begin
      bad++;
      $display("FAIL b2b_bus_spacing: got %0d %0d want 3 3",
               o2.accept_cyc - o1.accept_cyc, o3.accept_cyc - o2.accept_cyc);
    end
    total++;
    if (o4.accept_cyc - o3.accept_cyc !== 2) begin
      bad++;
      $display("FAIL b2b_short_spacing: got %0d want 2", o4.accept_cyc - o3.accept_cyc);
    end
    total++;
    if (o2.wstrb !== 4'b1100 || o2.wdata !== 32'hBEEF_BEEF || o4.rdata !== 32'h0000_00F0) begin
      bad++;
      $display("FAIL b2b_data: got wstrb=%b wdata=%h rdata=%h want 1100 beefbeef 000000f0",
               o2.wstrb, o2.wdata, o4.rdata);
    end
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    bit          rd, wr, ze;
    logic [1:0]  w;
    logic [31:0] a, wd, br;
    int          waits;
    for (int n = 0; n < 80; n++) begin
      rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
      ze = 1'($urandom_range(0, 1)); w = 2'($urandom_range(0, 3));
      a = $urandom; wd = $urandom; br = $urandom; waits = $urandom_range(0, 3);
      e = model(rd, wr, w, ze, a, wd, br, waits);
      run_op(rd, wr, w, ze, a, wd, br, waits, o);
      total++;
      if (o.saw_bus !== e.bus || o.lat !== e.lat || o.mis !== e.mis || o.timeout) begin
        bad++;
        $display("FAIL rand%0d_flow: got bus=%b lat=%0d mis=%b want %b %0d %b",
                 n, o.saw_bus, o.lat, o.mis, e.bus, e.lat, e.mis);
      end
      total++;
      if (o.rdata !== e.rdata) begin
        bad++;
        $display("FAIL rand%0d_rdata: got %h want %h (w=%0d ze=%b a=%h br=%h)",
                 n, o.rdata, e.rdata, w, ze, a, br);
      end
      total++;
      if (!o.pulse_ok || !o.held_ok || !o.ready_start || !o.ready_low) begin
        bad++;
        $display("FAIL rand%0d_handshake: got pulse=%b held=%b ready=%b low=%b want 1 1 1 1",
                 n, o.pulse_ok, o.held_ok, o.ready_start, o.ready_low);
      end
      if (e.bus) begin
        total++;
        if (o.baddr !== e.baddr || o.we !== e.we || o.wstrb !== e.wstrb || !o.stable ||
            (e.we && o.wdata !== e.wdata)) begin
          bad++;
          $display("FAIL rand%0d_bus: got addr=%h we=%b wstrb=%b wdata=%h stable=%b want %h %b %b %h 1",
                   n, o.baddr, o.we, o.wstrb, o.wdata, o.stable, e.baddr, e.we, e.wstrb, e.wdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_store();
    test_half_load();
    test_byte_load_sign();
    test_misaligned();
    test_wait_states();
    test_reset_mid_bus();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
